// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top, its byte packer and the bench.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        CHECK_LEN,
        LOAD,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the loader.
// slave is the loader side; master is the stream source / memory side.
interface imem_loader_if;

    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_write_out;

    modport slave (
        input  byte_in,
        input  byte_valid_in,
        output byte_ready_out,
        output mem_addr_out,
        output mem_data_out,
        output mem_write_out
    );

    modport master (
        output byte_in,
        output byte_valid_in,
        input  byte_ready_out,
        input  mem_addr_out,
        input  mem_data_out,
        input  mem_write_out
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word shift register with byte index and full flag.
// o_full is high for the one cycle after the last byte of a word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [1:0]  o_idx,
    output logic        o_full
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic        r_full;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_word <= {r_word[23:0], i_byte};
            r_idx  <= r_idx + 2'd1;
            r_full <= (r_idx == 2'(BYTES_PER_WORD - 1));
        end else begin
            r_full <= 1'b0;
        end
    end

    assign o_word = r_word;
    assign o_idx  = r_idx;
    assign o_full = r_full;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes instruction memory,
// and holds the core in reset until the program and checksum are accepted.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_in,
    imem_loader_if.slave           bus,
    input  logic                   reload_in,
    output logic                   cpu_reset_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic [COUNT_WIDTH-1:0] words_loaded_out
);

    localparam logic [COUNT_WIDTH:0] CAPACITY =
        (COUNT_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_t r_state;
    state_t w_next;

    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_words;
    logic [7:0]             r_csum;
    logic [31:0]            r_addr;
    logic [31:0]            r_data;

    logic        w_ready;
    logic        w_xfer;
    logic        w_write;
    logic        w_reload;
    logic        w_pack_load;
    logic        w_pack_clear;
    logic        w_full;
    logic [1:0]  w_idx;
    logic [31:0] w_word;
    logic [31:0] w_addr;

    assign w_xfer       = w_ready & bus.byte_valid_in;
    assign w_pack_clear = reset_in | w_reload;
    assign w_addr       = 32'({r_words[ADDR_WIDTH-1:0], 2'b00});

    byte_packer u_packer (
        .clk     (clk),
        .i_clear (w_pack_clear),
        .i_load  (w_pack_load),
        .i_byte  (bus.byte_in),
        .o_word  (w_word),
        .o_idx   (w_idx),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset_in) r_state <= HDR_HI;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_write     = 1'b0;
        w_reload    = 1'b0;
        w_pack_load = 1'b0;
        unique case (r_state)
            HDR_HI: begin
                w_ready = 1'b1;
                if (bus.byte_valid_in) w_next = HDR_LO;
            end
            HDR_LO: begin
                w_ready = 1'b1;
                if (bus.byte_valid_in) w_next = CHECK_LEN;
            end
            CHECK_LEN: begin
                if ({1'b0, r_count} > CAPACITY) w_next = ERROR;
                else if (r_count == '0)         w_next = CSUM;
                else                            w_next = LOAD;
            end
            LOAD: begin
                w_ready     = 1'b1;
                w_pack_load = bus.byte_valid_in;
                if (bus.byte_valid_in &&
                    w_idx == 2'(BYTES_PER_WORD - 1))
                    w_next = WRITE;
            end
            WRITE: begin
                w_write = w_full;
                if (r_words + COUNT_WIDTH'(1) == r_count) w_next = CSUM;
                else                                      w_next = LOAD;
            end
            CSUM: begin
                w_ready = 1'b1;
                if (bus.byte_valid_in)
                    w_next = (bus.byte_in == r_csum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (reload_in) begin
                    w_reload = 1'b1;
                    w_next   = HDR_HI;
                end
            end
            default: w_next = HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_count <= '0;
            r_words <= '0;
            r_csum  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_reload) begin
                r_words <= '0;
                r_csum  <= '0;
            end
            if (r_state == HDR_HI && w_xfer)
                r_count <= COUNT_WIDTH'({bus.byte_in, 8'h00});
            if (r_state == HDR_LO && w_xfer)
                r_count <= r_count | COUNT_WIDTH'(bus.byte_in);
            if (w_pack_load)
                r_csum <= r_csum ^ bus.byte_in;
            if (w_write) begin
                r_words <= r_words + COUNT_WIDTH'(1);
                r_addr  <= w_addr;
                r_data  <= w_word;
            end
        end
    end

    // Address/data are live during the strobe and hold afterwards.
    assign bus.mem_write_out  = w_write;
    assign bus.mem_addr_out   = w_write ? w_addr : r_addr;
    assign bus.mem_data_out   = w_write ? w_word : r_data;
    assign bus.byte_ready_out = w_ready;

    assign cpu_reset_out    = (r_state != DONE);
    assign done_out         = (r_state == DONE);
    assign error_out        = (r_state == ERROR);
    assign words_loaded_out = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random streams vs a stream-level model.
// Expected writes are queued by the driver and popped by a write monitor.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int AW = 8;
    localparam int CW = 16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          reload_in = 1'b0;
    logic          cpu_reset_out;
    logic          done_out;
    logic          error_out;
    logic [CW-1:0] words_loaded_out;

    imem_loader_if bus ();

    imem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset_in         (reset_in),
        .bus              (bus.slave),
        .reload_in        (reload_in),
        .cpu_reset_out    (cpu_reset_out),
        .done_out         (done_out),
        .error_out        (error_out),
        .words_loaded_out (words_loaded_out)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.mem_write_out === 1'b1) begin
            chk("no_back_to_back_write", prev_wr, 0);
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         bus.mem_addr_out, bus.mem_data_out);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", bus.mem_addr_out, e.addr);
                chk("wr_data", bus.mem_data_out, e.data);
                chk("wr_latency_cycle", cyc, e.cyc);
            end
        end
        prev_wr = bus.mem_write_out;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             input bit push, input logic [31:0] a,
                             input logic [31:0] d);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.byte_in = b;
        bus.byte_valid_in = 1'b1;
        w = 0;
        while (!bus.byte_ready_out && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.byte_ready_out) begin
            n_chk++;
            $display("FAIL ready_timeout: byte %0h not accepted in %0d cycles", b, w);
            bus.byte_valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back('{addr: a, data: d, cyc: cyc + 1});
        @(negedge clk);
        bus.byte_valid_in = 1'b0;
    endtask

    task automatic run_load(input int n, input bq_t pl, input logic [7:0] cs,
                            input bit gaps);
        logic [15:0] nn;
        logic [7:0]  x;
        logic [31:0] wd;
        bit          good;
        int          t;
        int          acc;
        nn = 16'(n);
        for (int i = 0; i < HEADER_BYTES; i++)
            send_byte(i == 0 ? nn[15:8] : nn[7:0], gaps, 1'b0, 0, 0);
        chk("cpu_reset_during_load", cpu_reset_out, 1);
        if (n > (1 << AW)) begin
            t = 0;
            while (!error_out && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("len_error", error_out, 1);
            chk("len_error_done", done_out, 0);
            chk("len_error_cpu_reset", cpu_reset_out, 1);
            bus.byte_in = 8'hA5;
            bus.byte_valid_in = 1'b1;
            acc = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.byte_ready_out) acc++;
            end
            bus.byte_valid_in = 1'b0;
            chk("len_error_no_accept", acc, 0);
            chk("len_error_words", words_loaded_out, 0);
            return;
        end
        x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        for (int i = 0; i < 4 * n; i++) begin
            wd = {pl[i - 3 + (i % 4 == 3 ? 0 : 3)], pl[i], pl[i], pl[i]};
            if (i % 4 == 3)
                wd = {pl[i - 3], pl[i - 2], pl[i - 1], pl[i]};
            send_byte(pl[i], gaps, i % 4 == 3, 32'((i / 4) * 4), wd);
        end
        send_byte(cs, gaps, 1'b0, 0, 0);
        good = (cs == x);
        t = 0;
        while (!(done_out || error_out) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("final_done", done_out, good);
        chk("final_error", error_out, !good);
        chk("final_cpu_reset", cpu_reset_out, !good);
        chk("final_words", words_loaded_out, n);
        chk("all_writes_seen", sb.size(), 0);
    endtask

    task automatic do_reload();
        reload_in = 1'b1;
        @(negedge clk);
        reload_in = 1'b0;
        chk("reload_done_clr", done_out, 0);
        chk("reload_error_clr", error_out, 0);
        chk("reload_cpu_reset", cpu_reset_out, 1);
        chk("reload_words_clr", words_loaded_out, 0);
        chk("reload_ready", bus.byte_ready_out, 1);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_mem_write"}, bus.mem_write_out, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr_out, 0);
        chk({tag, "_mem_data"}, bus.mem_data_out, 0);
        chk({tag, "_cpu_reset"}, cpu_reset_out, 1);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_error"}, error_out, 0);
        chk({tag, "_words"}, words_loaded_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t pl;
        bq_t rp;
        int  n;
        logic [7:0] x;
        bus.byte_in = 8'h00;
        bus.byte_valid_in = 1'b0;
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_in = 1'b0;
        chk("ready_after_reset", bus.byte_ready_out, 1);

        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(2, pl, 8'h00, 1'b0);
        do_reload();
        run_load(2, pl, 8'h08, 1'b0);
        do_reload();
        run_load(2, pl, 8'h09, 1'b0);
        do_reload();
        rp = {};
        run_load(0, rp, 8'h00, 1'b0);
        do_reload();
        run_load(0, rp, 8'h5A, 1'b0);
        do_reload();
        run_load(16'h0101, rp, 8'h00, 1'b0);
        do_reload();
        run_load(2, pl, 8'h00, 1'b1);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 6);
            rp = {};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                rp.push_back(8'($urandom));
                x ^= rp[i];
            end
            if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
            do_reload();
            run_load(n, rp, x, 1'($urandom_range(0, 1)));
        end

        rp = {};
        x = 8'h00;
        for (int i = 0; i < 4 * (1 << AW); i++) begin
            rp.push_back(8'($urandom));
            x ^= rp[i];
        end
        do_reload();
        run_load(1 << AW, rp, x, 1'b0);

        // Abort mid-load after one full word and one extra byte.
        do_reload();
        send_byte(8'h00, 1'b0, 1'b0, 0, 0);
        send_byte(8'h03, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++)
            send_byte(pl[i], 1'b0, i == 3, 32'h0, 32'h12345678);
        reset_in = 1'b1;
        @(negedge clk);
        check_reset_vals("midload_reset");
        reset_in = 1'b0;
        chk("ready_after_midload_reset", bus.byte_ready_out, 1);
        rp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, rp, 8'h22, 1'b0);

        do_reload();
        run_load(1, rp, 8'h22, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
